// File: rtl/float_pcm_pkg.sv
// float_pcm_pkg: shared float32 field constants, the sample class enum and
// the PCM full-scale helpers used by float_to_pcm.
package float_pcm_pkg;

  localparam int FP_BIAS     = 127;
  localparam int FP_EXP_MAX  = 255;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_HI   = 30;
  localparam int FP_EXP_LO   = 23;
  localparam int FP_MAN_HI   = 22;
  localparam int FP_MAN_W    = 23;

  // ZERO: zero/denormal, NORMAL: |x| < 1, SAT: |x| >= 1 or Inf, NAN: NaN
  typedef enum logic [1:0] {ZERO, NORMAL, SAT, NAN} cls_e;

  function automatic int pcm_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int pcm_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: synchronous FIFO with synchronous active-low reset.
// Ports: clk, rst_n, push_i/data_i (write), pop_i (read head), data_o (head,
// 0 while empty), full_o, empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module pcm_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // extra MSB separates full from empty after wrap-around
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/float_to_pcm.sv
// float_to_pcm: captures float32 samples on sample_valid, converts them to
// saturated two's-complement PCM in a 3-stage pipeline and buffers them in
// pcm_fifo behind a valid/ready handshake.
// Ports: clk, aclr_n (sync, active-low), sample_in/sample_valid (capture),
// pcm_out/pcm_valid/pcm_ready (output handshake), clip (1-cycle pulse on a
// saturated or NaN sample), overrun (sticky, sample dropped on full FIFO).
// Optional: FLOAT_TO_PCM_CLIP_COUNT_EN adds clip_count, a 16-bit saturating
// count of clip pulses.
module float_to_pcm
  import float_pcm_pkg::*;
#(
  parameter int PCM_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic [31:0]      sample_in,
  input  logic             sample_valid,
  output logic [PCM_W-1:0] pcm_out,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             clip,
  output logic             overrun
`ifdef FLOAT_TO_PCM_CLIP_COUNT_EN
  ,
  output logic [15:0]      clip_count
`endif
);

  localparam int STAGES = 3;
  localparam logic [PCM_W-1:0] PMAX = PCM_W'(pcm_max(PCM_W));
  localparam logic [PCM_W-1:0] PMIN = PCM_W'(pcm_min(PCM_W));

  // ---------------- classify (feeds S1) ----------------
  logic                s_in;
  logic [7:0]          e_in;
  logic [FP_MAN_W-1:0] m_in;
  logic [7:0]          sh_full;
  cls_e                cls_d;
  logic                clip_d;
  logic [4:0]          sh_d;

  assign s_in = sample_in[FP_SIGN_BIT];
  assign e_in = sample_in[FP_EXP_HI:FP_EXP_LO];
  assign m_in = sample_in[FP_MAN_HI:0];
  // meaningful only for e < bias; ranges 1..135 there
  assign sh_full = 8'(FP_BIAS) - e_in + 8'(24 - PCM_W);

  always_comb begin
    cls_d  = NORMAL;
    clip_d = 1'b0;
    sh_d   = (sh_full >= 8'd24) ? 5'd24 : sh_full[4:0];
    if (e_in == 8'd0) begin
      cls_d = ZERO;
    end else if (e_in == 8'(FP_EXP_MAX) && m_in != '0) begin
      cls_d  = NAN;
      clip_d = 1'b1;
    end else if (e_in >= 8'(FP_BIAS)) begin
      cls_d  = SAT;
      // exactly -1.0 is representable as PCM_MIN, so it is not a clip
      clip_d = !(s_in && e_in == 8'(FP_BIAS) && m_in == '0);
    end
  end

  // ---------------- pipeline registers ----------------
  logic [STAGES:1] vld_pipe_q;
  logic            s1_s_q, s2_s_q;
  cls_e            s1_cls_q, s2_cls_q;
  logic            s1_clip_q, s2_clip_q, s3_clip_q;
  logic [23:0]     s1_man_q;
  logic [4:0]      s1_sh_q;
  logic [PCM_W-1:0] s2_mag_q, s3_res_q;

  logic [23:0]      mag_full;
  logic [PCM_W-1:0] res_d;

  // sh >= 24 shifts everything out, leaving 0
  assign mag_full = s1_man_q >> s1_sh_q;

  // NORMAL magnitudes are < 2^(PCM_W-1), so negation never overflows
  always_comb begin
    res_d = '0;
    unique case (s2_cls_q)
      ZERO:    res_d = '0;
      NAN:     res_d = '0;
      SAT:     res_d = s2_s_q ? PMIN : PMAX;
      NORMAL:  res_d = s2_s_q ? (~s2_mag_q + 1'b1) : s2_mag_q;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      vld_pipe_q <= '0;
      s1_s_q     <= 1'b0;
      s1_cls_q   <= ZERO;
      s1_clip_q  <= 1'b0;
      s1_man_q   <= '0;
      s1_sh_q    <= '0;
      s2_s_q     <= 1'b0;
      s2_cls_q   <= ZERO;
      s2_clip_q  <= 1'b0;
      s2_mag_q   <= '0;
      s3_clip_q  <= 1'b0;
      s3_res_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], sample_valid};
      // S1: capture + classify
      s1_s_q     <= s_in;
      s1_cls_q   <= cls_d;
      s1_clip_q  <= clip_d;
      s1_man_q   <= {1'b1, m_in};
      s1_sh_q    <= sh_d;
      // S2: barrel shift
      s2_s_q     <= s1_s_q;
      s2_cls_q   <= s1_cls_q;
      s2_clip_q  <= s1_clip_q;
      s2_mag_q   <= mag_full[PCM_W-1:0];
      // S3: negate / saturate
      s3_clip_q  <= s2_clip_q;
      s3_res_q   <= res_d;
    end
  end

  // ---------------- output FIFO ----------------
  logic fifo_full, fifo_empty, push, drop;
  logic clip_q, overrun_q;

  assign push = vld_pipe_q[STAGES];
  // a full FIFO is never empty, so pcm_ready alone means a pop happens
  assign drop = push && fifo_full && !pcm_ready;

  pcm_fifo #(
    .W     (PCM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (aclr_n),
    .push_i  (push),
    .data_i  (s3_res_q),
    .pop_i   (pcm_ready),
    .data_o  (pcm_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      clip_q    <= push && s3_clip_q;
      overrun_q <= overrun_q | drop;
    end
  end

  assign pcm_valid = !fifo_empty;
  assign clip      = clip_q;
  assign overrun   = overrun_q;

`ifdef FLOAT_TO_PCM_CLIP_COUNT_EN
  logic [15:0] clip_count_q;

  always_ff @(posedge clk) begin
    if (!aclr_n)                               clip_count_q <= '0;
    else if (clip_q && clip_count_q != 16'hFFFF) clip_count_q <= clip_count_q + 16'd1;
  end

  assign clip_count = clip_count_q;
`endif

endmodule

// File: tb/tb_float_to_pcm.sv
// Directed testbench for float_to_pcm (PCM_W = 24, FIFO_DEPTH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_float_to_pcm;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic [23:0] pcm_out;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        clip;
  logic        overrun;
`ifdef FLOAT_TO_PCM_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  float_to_pcm #(.PCM_W(24), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .aclr_n       (aclr_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .pcm_out      (pcm_out),
    .pcm_valid    (pcm_valid),
    .pcm_ready    (pcm_ready),
    .clip         (clip),
    .overrun      (overrun)
`ifdef FLOAT_TO_PCM_CLIP_COUNT_EN
    ,
    .clip_count   (clip_count)
`endif
  );

  // single-sample conversion vectors: input, expected PCM, expected clip
  logic [31:0] cv_in  [16] = '{32'h3F000000, 32'hBF000000, 32'h3E800001, 32'h33000000,
                               32'h3F800000, 32'hBF800000, 32'hFF800000, 32'h7FC00000,
                               32'h00000000, 32'h00000001, 32'h7F800000, 32'h80000000,
                               32'hB3000000, 32'h3F7FFFFF, 32'hBF7FFFFF, 32'h40400000};
  logic [23:0] cv_exp [16] = '{24'h400000, 24'hC00000, 24'h200000, 24'h000000,
                               24'h7FFFFF, 24'h800000, 24'h800000, 24'h000000,
                               24'h000000, 24'h000000, 24'h7FFFFF, 24'h000000,
                               24'h000000, 24'h7FFFFF, 24'h800001, 24'h7FFFFF};
  logic        cv_clip[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic do_reset();
    @(negedge clk);
    aclr_n = 1'b0; sample_valid = 1'b0; sample_in = '0; pcm_ready = 1'b0;
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
  endtask

  // drive a one-cycle strobe; returns on the falling edge after capture
  task automatic strobe(input logic [31:0] x);
    sample_in = x; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    aclr_n = 1'b0; sample_valid = 1'b1; sample_in = 32'h3F000000; pcm_ready = 1'b0;
    repeat (6) @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    nvec++; if (pcm_out !== 24'h0) begin nerr++; $display("FAIL reset_pcm_out got %h want 000000", pcm_out); end
    nvec++; if (pcm_valid !== 1'b0) begin nerr++; $display("FAIL reset_pcm_valid got %b want 0", pcm_valid); end
    nvec++; if (clip !== 1'b0) begin nerr++; $display("FAIL reset_clip got %b want 0", clip); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun got %b want 0", overrun); end
    aclr_n = 1'b1;
  endtask

  task automatic test_convert();
    do_reset();
    pcm_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      strobe(cv_in[i]);          // now after capture edge E0
      @(negedge clk);            // after E1
      @(negedge clk);            // after E2
      nvec++; if (pcm_valid !== 1'b0) begin nerr++; $display("FAIL conv_early[%0d] pcm_valid got %b want 0", i, pcm_valid); end
      @(negedge clk);            // after E3: FIFO written
      nvec++; if (pcm_valid !== 1'b1 || pcm_out !== cv_exp[i]) begin
        nerr++; $display("FAIL conv[%0d] in %h got valid %b out %h want valid 1 out %h", i, cv_in[i], pcm_valid, pcm_out, cv_exp[i]);
      end
      nvec++; if (clip !== cv_clip[i]) begin nerr++; $display("FAIL conv_clip[%0d] got %b want %b", i, clip, cv_clip[i]); end
      @(negedge clk);            // popped
      nvec++; if (pcm_valid !== 1'b0 || clip !== 1'b0) begin
        nerr++; $display("FAIL conv_after[%0d] got valid %b clip %b want 0 0", i, pcm_valid, clip);
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] xin [5] = '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000, 32'h3D000000};
    logic [23:0] xexp[4] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) strobe(xin[i]);
    repeat (6) @(negedge clk);
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_flag got %b want 1", overrun); end
    nvec++; if (pcm_valid !== 1'b1 || pcm_out !== 24'h400000) begin
      nerr++; $display("FAIL ovr_hold got valid %b out %h want 1 400000", pcm_valid, pcm_out);
    end
    pcm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nvec++; if (pcm_valid !== 1'b1 || pcm_out !== xexp[i]) begin
        nerr++; $display("FAIL ovr_drain[%0d] got valid %b out %h want 1 %h", i, pcm_valid, pcm_out, xexp[i]);
      end
      @(negedge clk);
    end
    nvec++; if (pcm_valid !== 1'b0) begin nerr++; $display("FAIL ovr_empty got %b want 0", pcm_valid); end
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    do_reset();
    @(negedge clk);
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_full_rw();
    logic [31:0] xin [4] = '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000};
    logic [23:0] xexp[4] = '{24'h200000, 24'h100000, 24'h080000, 24'h600000};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) strobe(xin[i]);
    repeat (5) @(negedge clk);
    strobe(32'h3F400000);        // 0.75, after E0
    @(negedge clk);              // after E1
    @(negedge clk);              // after E2
    pcm_ready = 1'b1;            // pop coincides with the write at E3
    @(negedge clk);
    pcm_ready = 1'b0;
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL fullrw_overrun got %b want 0", overrun); end
    @(negedge clk);
    pcm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nvec++; if (pcm_valid !== 1'b1 || pcm_out !== xexp[i]) begin
        nerr++; $display("FAIL fullrw_drain[%0d] got valid %b out %h want 1 %h", i, pcm_valid, pcm_out, xexp[i]);
      end
      @(negedge clk);
    end
    nvec++; if (pcm_valid !== 1'b0) begin nerr++; $display("FAIL fullrw_empty got %b want 0", pcm_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xin [4] = '{32'h3F000000, 32'hBF800000, 32'h3F800000, 32'hBF000000};
    logic [23:0] xexp[4] = '{24'h400000, 24'h800000, 24'h7FFFFF, 24'hC00000};
    logic        xclp[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    pcm_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) strobe(xin[i]);  // after E3 of the first sample
    for (int i = 0; i < 4; i++) begin
      nvec++; if (pcm_valid !== 1'b1 || pcm_out !== xexp[i] || clip !== xclp[i]) begin
        nerr++; $display("FAIL b2b[%0d] got valid %b out %h clip %b want 1 %h %b", i, pcm_valid, pcm_out, clip, xexp[i], xclp[i]);
      end
      @(negedge clk);
    end
    nvec++; if (pcm_valid !== 1'b0) begin nerr++; $display("FAIL b2b_empty got %b want 0", pcm_valid); end
  endtask

  task automatic test_mid_reset();
    logic seen = 1'b0;
    do_reset();
    pcm_ready = 1'b0;
    @(negedge clk);
    strobe(32'h3F000000);        // after E0
    @(negedge clk);              // after E1: cycle N+2
    aclr_n = 1'b0;
    @(negedge clk);
    aclr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pcm_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL midrst got late pcm_valid %b want 0", seen); end
  endtask

  task automatic test_clip_count();
`ifdef FLOAT_TO_PCM_CLIP_COUNT_EN
    do_reset();
    pcm_ready = 1'b1;
    @(negedge clk);
    nvec++; if (clip_count !== 16'd0) begin nerr++; $display("FAIL cc_reset got %0d want 0", clip_count); end
    for (int i = 0; i < 3; i++) strobe(32'h3F800000);
    repeat (6) @(negedge clk);
    nvec++; if (clip_count !== 16'd3) begin nerr++; $display("FAIL cc_count got %0d want 3", clip_count); end
`endif
  endtask

  initial begin
    aclr_n = 1'b0; sample_in = '0; sample_valid = 1'b0; pcm_ready = 1'b0;
    test_reset();
    test_convert();
    test_overrun();
    test_full_rw();
    test_back_to_back();
    test_mid_reset();
    test_clip_count();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/float_to_pcm.md
# float_to_pcm

Output-side sample converter that sits directly downstream of the distortion stage. It captures each IEEE-754 single-precision result when the distortion stage pulses `ready_to_read`, converts it to signed fixed-point PCM with saturation, and buffers the result in a small FIFO. A valid/ready handshake feeds the DAC serializer. The upstream stage has no backpressure input, so overflow is handled locally by dropping samples and recording a sticky flag.

## Interface
- `PCM_W`, default 24: PCM word width; legal range 16..24.
- `FIFO_DEPTH`, default 4: output buffer entries; must be a power of 2, minimum 2.

- `clk`, in, 1: single clock.
- `aclr_n`, in, 1: reset, synchronous, active-low; all state is reset on a `clk` edge while low.
- `sample_in`, in, 32: float32 sample; connects to distortion `out`.
- `sample_valid`, in, 1: one-cycle capture strobe; connects to distortion `ready_to_read`.
- `pcm_out`, out, `PCM_W`: FIFO head, two's complement.
- `pcm_valid`, out, 1: FIFO non-empty.
- `pcm_ready`, in, 1: consumer accepts the head when `pcm_valid && pcm_ready`.
- `clip`, out, 1: one-cycle pulse when a saturated or NaN sample is written to the FIFO.
- `overrun`, out, 1: sticky; set when a converted sample is dropped because the FIFO is full. Cleared only by reset.

## Operation
Fields: sign `s = x[31]`, exponent `e = x[30:23]`, mantissa `m = x[22:0]`. Nominal range is [-1, 1), scaled by 2^(PCM_W-1).

- **Zero or denormal** (`e == 0`): result is 0, no clip.
- **NaN** (`e == 255`, `m != 0`): result is 0, `clip` pulses.
- **±Inf or |x| ≥ 1** (`e ≥ 127`): result is `PCM_MAX = 2^(PCM_W-1)-1` if `s == 0`. If `s == 1`, result is `PCM_MIN`, and `clip` pulses unless the input is exactly -1.0 (`e == 127`, `m == 0`).
- **Otherwise**:
  - Magnitude = `{1'b1, m} >> sh`, where `sh = (127 - e) + (24 - PCM_W)`. Truncate toward zero. If `sh ≥ 24`, magnitude is 0.
  - Result = `s ? -mag : mag`. Negative zero gives 0.

Pipeline, three stages, each with its own valid bit:
- S1: register the sample, classify it, compute `sh`.
- S2: barrel shift.
- S3: negate and saturate, then FIFO write request.

FIFO behaviour:
- Write with FIFO not full: entry stored.
- Write with FIFO full and no simultaneous read: sample dropped, `overrun` set. `clip` still pulses if that sample clipped.
- Read and write in the same cycle while full: both succeed, occupancy is unchanged.
- Read when empty: no effect.
- `pcm_out` holds its value while `pcm_valid && !pcm_ready`. Entries leave in write order.

`sample_valid` on consecutive cycles is legal: one conversion per cycle, no bubbles.

## Timing
- **Reset values:** `pcm_out` = 0, `pcm_valid` = 0, `clip` = 0, `overrun` = 0. Pipeline valid bits cleared, FIFO empty.
- **Latency:** `sample_valid` in cycle N gives a FIFO write at the end of cycle N+3. With the FIFO empty, `pcm_valid` = 1 in cycle N+4 and `clip` pulses in cycle N+4.
- **Throughput:** one sample per clock.
- **Reset mid-operation:** samples in flight are discarded, with no late `pcm_valid` after reset releases.
- **Full/empty detection:** uses a pointer width of `log2(FIFO_DEPTH)+1`; the extra MSB distinguishes full from empty on wrap-around.

## Configuration
- `FLOAT_TO_PCM_CLIP_COUNT_EN` defined:
  - Adds output `clip_count`, 16 bits, reset to 0.
  - Increments by 1 on every `clip` pulse and saturates at 0xFFFF.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `float_pcm_pkg` holds:
  - float32 field constants (`FP_BIAS = 127`, `FP_EXP_MAX = 255`, field bit positions);
  - the sample class enum (`ZERO`, `NORMAL`, `SAT`, `NAN`);
  - the functions `pcm_max(PCM_W)` and `pcm_min(PCM_W)`.
- One sub-module, `pcm_fifo`: a synchronous FIFO (parameters `W`, `DEPTH`) with push, pop, full and empty. Conversion stays in `float_to_pcm`.

## Test plan
- `sample_in` 0x3F000000 (0.5), one strobe, `pcm_ready` = 1 -> `pcm_out` 0x400000 with `pcm_valid` 4 cycles later; `clip` = 0.
- 0xBF000000 (-0.5) -> 0xC00000. 0x3E800001 -> 0x200000 (truncation). 0x33000000 (2^-25) -> 0x000000.
- 0x3F800000 (1.0) -> 0x7FFFFF with `clip` pulse. 0xBF800000 (-1.0) -> 0x800000 with no `clip`. 0xFF800000 (-Inf) -> 0x800000 with `clip`. 0x7FC00000 (NaN) -> 0x000000 with `clip`.
- `pcm_ready` = 0, strobe samples 0.5, 0.25, 0.125, 0.0625, then 0.03125 -> four entries held, `overrun` = 1. Raise `pcm_ready` -> 0x400000, 0x200000, 0x100000, 0x080000 in order, then `pcm_valid` = 0.
- FIFO full with `pcm_ready` = 1 and a write in the same cycle -> no drop, `overrun` stays 0. Strobe on consecutive cycles -> one output per cycle.
- Strobe 0.5 at cycle N, `aclr_n` low at cycle N+2 -> `pcm_valid` never rises. Then with `FLOAT_TO_PCM_CLIP_COUNT_EN` defined, drive three 1.0 samples -> `clip_count` = 3.
